sram_controller: RTL and testbench

Data-memory responder for the 5-stage ARM pipeline. It accepts 32-bit word read/write requests from the MEM stage and serves them from an external 256K x 16 SRAM, using two halfword accesses per word. While a transaction is in flight it deasserts `ready`, and the top level turns that into a pipeline freeze. It is the memory-side end of the MEM stage's load/store interface.

---
 rtl/sram_controller.sv | 108 ++++++++++
 tb/tb_sram_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Data-memory responder for the MEM stage: serves 32-bit loads/stores from a
// 256K x 16 SRAM as two halfword phases, holding ready low while busy.
module sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned ADDR_OFFSET   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        write_q;
    logic        req;
    logic        cnt_last;
    logic [16:0] word;

    assign req      = mem_r_en | mem_w_en;
    assign cnt_last = (cnt == 4'(ACCESS_CYCLES - 1));
    assign word     = 17'((addr - 32'(ADDR_OFFSET)) >> 2);
    assign ready    = (state == DONE) || ((state == IDLE) && !req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (req) begin
                        word_q  <= word;
                        wdata_q <= wdata;
                        write_q <= mem_w_en;
                        cnt     <= '0;
                    end
                end
                LO, HI: begin
                    cnt <= cnt_last ? '0 : cnt + 4'd1;
                    // Read data is sampled on the final cycle of each phase.
                    if (cnt_last && !write_q) begin
                        if (state == LO) rdata[15:0]  <= sram_dq_in;
                        else             rdata[31:16] <= sram_dq_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state  = state;
        sram_addr   = {word_q, 1'b0};
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            IDLE: begin
                if (req) next_state = LO;
            end
            LO: begin
                sram_we_n   = !write_q;
                sram_dq_oe  = write_q;
                sram_dq_out = write_q ? wdata_q[15:0] : '0;
                if (cnt_last) next_state = HI;
            end
            HI: begin
                sram_addr   = {word_q, 1'b1};
                sram_we_n   = !write_q;
                sram_dq_oe  = write_q;
                sram_dq_out = write_q ? wdata_q[31:16] : '0;
                if (cnt_last) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: A=2 instance against an SRAM model,
// plus an A=1 instance for the short-phase timing.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n;

    logic        r_en_b, w_en_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic        ready_b;
    logic [17:0] sram_addr_b;
    logic [15:0] sram_dq_out_b, sram_dq_in_b;
    logic        sram_dq_oe_b, sram_we_n_b;

    logic [15:0] sram_mem [0:262143];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_controller #(.ACCESS_CYCLES(2), .ADDR_OFFSET(1024)) u_dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.ACCESS_CYCLES(1), .ADDR_OFFSET(1024)) u_dut_b (
        .clk(clk), .rst(rst), .mem_r_en(r_en_b), .mem_w_en(w_en_b),
        .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b),
        .sram_addr(sram_addr_b), .sram_dq_out(sram_dq_out_b), .sram_dq_oe(sram_dq_oe_b),
        .sram_dq_in(sram_dq_in_b), .sram_we_n(sram_we_n_b)
    );

    // Asynchronous-read SRAM; writes land while the strobe is low.
    assign sram_dq_in   = sram_mem[sram_addr];
    assign sram_dq_in_b = 16'hA5A5;

    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full A=2 transaction: cycle 0 IDLE, 1-2 LO, 3-4 HI, 5 DONE.
    task automatic txn(input string tag, input logic re, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [17:0] lo_addr, input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        mem_r_en = re; mem_w_en = we; addr = a; wdata = wd;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            check($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'(c == 5));
            if (c >= 1 && c <= 4) begin
                check($sformatf("%s_addr_c%0d", tag, c), 32'(sram_addr),
                      32'(lo_addr + ((c >= 3) ? 18'd1 : 18'd0)));
                check($sformatf("%s_we_n_c%0d", tag, c), 32'(sram_we_n), 32'(!we));
                check($sformatf("%s_oe_c%0d", tag, c), 32'(sram_dq_oe), 32'(we));
                check($sformatf("%s_dq_c%0d", tag, c), 32'(sram_dq_out),
                      we ? ((c >= 3) ? 32'(wd[31:16]) : 32'(wd[15:0])) : 32'd0);
            end else begin
                check($sformatf("%s_we_n_c%0d", tag, c), 32'(sram_we_n), 32'd1);
                check($sformatf("%s_oe_c%0d", tag, c), 32'(sram_dq_oe), 32'd0);
            end
        end
        check($sformatf("%s_rdata", tag), rdata, exp_rdata);
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wdata = '0;
        r_en_b = 1'b0; w_en_b = 1'b0; addr_b = 32'd1024; wdata_b = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rdata", rdata, 32'd0);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_dq", 32'(sram_dq_out), 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;

        txn("store", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 32'd0);
        check("store_mem2", 32'(sram_mem[2]), 32'h0000BEEF);
        check("store_mem3", 32'(sram_mem[3]), 32'h0000DEAD);
        txn("load", 1'b1, 1'b0, 32'd1028, 32'd0, 18'd2, 32'hDEADBEEF);
        txn("both", 1'b1, 1'b1, 32'd1024, 32'h12345678, 18'd0, 32'hDEADBEEF);
        check("both_mem0", 32'(sram_mem[0]), 32'h00005678);
        check("both_mem1", 32'(sram_mem[1]), 32'h00001234);
        txn("unalign", 1'b1, 1'b0, 32'd1027, 32'd0, 18'd0, 32'h12345678);

        // Back-to-back loads with the request held throughout.
        @(posedge clk); #1;
        mem_r_en = 1'b1; addr = 32'd1028;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), 32'(ready), 32'(c == 5 || c == 11));
        end
        check("b2b_rdata", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        mem_r_en = 1'b0;

        // Flush: request dropped in cycle 2, transaction still completes.
        @(posedge clk); #1;
        mem_r_en = 1'b1; addr = 32'd1024;
        for (int c = 0; c <= 6; c++) begin
            if (c == 2) begin
                @(posedge clk); #1;
                mem_r_en = 1'b0;
            end
            @(negedge clk);
            check($sformatf("flush_ready_c%0d", c), 32'(ready), 32'(c >= 5));
            check($sformatf("flush_we_n_c%0d", c), 32'(sram_we_n), 32'd1);
            if (c == 5) check("flush_rdata", rdata, 32'h12345678);
        end

        // Reset asserted in the middle of a write's low phase.
        @(posedge clk); #1;
        mem_w_en = 1'b1; addr = 32'd1032; wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check("rstmid_pre_we_n", 32'(sram_we_n), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("rstmid_we_n", 32'(sram_we_n), 32'd1);
        check("rstmid_oe", 32'(sram_dq_oe), 32'd0);
        check("rstmid_ready_req", 32'(ready), 32'd0);
        mem_w_en = 1'b0;
        #1;
        check("rstmid_ready_idle", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstrel_ready", 32'(ready), 32'd1);
        check("rstrel_rdata", rdata, 32'd0);

        // A=1 instance: ready rises at cycle 3.
        @(posedge clk); #1;
        r_en_b = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("a1_ready_c%0d", c), 32'(ready_b), 32'(c == 3));
            if (c == 1) begin
                check("a1_addr_lo", 32'(sram_addr_b), 32'd0);
                check("a1_we_n", 32'(sram_we_n_b), 32'd1);
                check("a1_oe", 32'(sram_dq_oe_b), 32'd0);
                check("a1_dq", 32'(sram_dq_out_b), 32'd0);
            end
            if (c == 2) check("a1_addr_hi", 32'(sram_addr_b), 32'd1);
            if (c == 3) check("a1_rdata", rdata_b, 32'hA5A5A5A5);
        end
        @(posedge clk); #1;
        r_en_b = 1'b0;
        @(negedge clk);
        check("a1_idle_ready", 32'(ready_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
